maze_move_ctrl: RTL and testbench
=================================

Name: maze_move_ctrl

Overview:
Player-movement sequencer for the maze game. It accepts one direction request at a time and reads the wall nibble for the player's current tile from the active level's combinational wall-lookup block. It checks walls and grid edges, then commits or rejects the move. It holds player position, move count and goal status for the renderer and game FSM.

Parameters:
START_ROW, 0, row loaded on reset/restart (3-bit)
START_COL, 0, col loaded on reset/restart (3-bit)
GOAL_ROW, 4, goal tile row
GOAL_COL, 4, goal tile col
CNT_W, 16, move_count width

Ports:
clk  in  1  system clock
rst_n  in  1  reset
restart  in  1  sync restart to start tile, highest priority
move_valid  in  1  direction request valid
move_dir  in  2  0=up(row-1), 1=right(col+1), 2=down(row+1), 3=left(col-1)
move_ready  out  1  request accepted when move_valid && move_ready
maze_row  out  3  tile row to wall lookup (= pos_row)
maze_col  out  3  tile col to wall lookup (= pos_col)
maze_walls  in  4  lookup result: [3]=up, [2]=right, [1]=down, [0]=left, 1=wall
num_rows  in  3  active level rows
num_cols  in  3  active level cols
pos_row  out  3  player row
pos_col  out  3  player col
moved  out  1  1-cycle pulse: move committed
blocked  out  1  1-cycle pulse: move rejected
at_goal  out  1  pos == goal
move_count  out  CNT_W  committed moves, saturating

Interface (already decided):
- One clock; reset is asynchronous and active-low. Clock port is clk; reset port is rst_n.

Behaviour:
- Reset (rst_n=0): state=IDLE, pos=(START_ROW,START_COL), move_count=0, moved=blocked=0, dir_q=0, walls_q=0. at_goal follows pos; move_ready=1 unless at_goal.
- States: IDLE, FETCH, CHECK, DONE.
- IDLE:
  - move_ready=1.
  - On handshake, latch move_dir into dir_q and go to FETCH.
  - If pos==goal, go to DONE instead; no handshake is possible there.
- FETCH:
  - move_ready=0.
  - maze_row/col are already driven from pos.
  - walls_q <= maze_walls at the end of the cycle; go to CHECK.
  - This one registered sample gives the lookup a full cycle.
- CHECK:
  - move_ready=0.
  - blk = walls_q[bit(dir_q)] | edge, where edge is: up && row==0; right && col==num_cols-1; down && row==num_rows-1; left && col==0.
  - If !blk: update pos, increment move_count (saturate at all-ones), and assert moved in the next cycle.
  - Else: pos unchanged, assert blocked in the next cycle.
  - Go to IDLE, or to DONE if the new pos==goal.
- Latency:
  - Handshake in cycle T; walls sampled at end of T+1; pos and count update at end of T+2.
  - moved/blocked are high in T+3, and move_ready is high again in T+3 (unless DONE).
  - Back-to-back moves are accepted every 3 cycles.
- DONE:
  - move_ready=0, at_goal=1.
  - Held until restart or reset; move_valid is ignored.
- restart (any state, including mid-FETCH/CHECK):
  - Next cycle: pos=start, move_count=0, state=IDLE.
  - No moved/blocked pulse; the in-flight move is dropped.
- move_dir is sampled only at the handshake; later changes are ignored.
- moved and blocked are mutually exclusive and never assert in IDLE except the single post-CHECK cycle.
- If START==GOAL: after reset, at_goal=1 and the first IDLE cycle goes to DONE with move_ready=0.
- num_rows/num_cols are sampled in CHECK only; they must not change mid-move. Arithmetic is 3-bit unsigned; edge checks prevent wrap.

Decomposition:
- Shared package maze_pkg:
  - DIR_UP/RIGHT/DOWN/LEFT codes
  - WALL_UP=3, WALL_RIGHT=2, WALL_DOWN=1, WALL_LEFT=0 bit indices
  - ROW_W=3, COL_W=3, WALL_W=4
  - state enum
- One combinational sub-module, maze_move_check: inputs walls/dir/pos/num_rows/num_cols; outputs blk, next_row, next_col. It is reused by any AI/replay controller.

Test Plan:
- Reset with START=(0,0): pos=(0,0), move_count=0, move_ready=1, at_goal=0, moved=blocked=0.
- Open move: stub returns walls=4'b0000 at (0,0); request dir=1 → move_ready low 2 cycles, pos=(0,1) at T+3, moved pulse 1 cycle, move_count=1.
- Wall block: walls=4'b0100 at (0,0); request dir=1 → blocked pulse at T+3, pos=(0,0), move_count=0. Same with walls=0 and dir=0 → blocked (edge).
- Far edge: num_cols=7, pos=(2,6), walls=0, dir=1 → blocked. num_rows=5, pos=(4,3), dir=2 → blocked.
- Goal: GOAL=(4,4), pos=(3,4), walls=0, dir=2 → pos=(4,4), at_goal=1, state DONE; further move_valid is never accepted. restart → pos=(0,0), count=0, move_ready=1.
- Abort and saturation: restart in the FETCH cycle → no pulse, pos=start. Preload count to 16'hFFFF via repeated moves (or force) → next committed move keeps 16'hFFFF.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared types and constants for the maze movement logic.
// Direction codes, wall-nibble bit positions and the move sequencer state encoding.
package maze_pkg;
    localparam int ROW_W  = 3;
    localparam int COL_W  = 3;
    localparam int WALL_W = 4;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    localparam int WALL_UP    = 3;
    localparam int WALL_RIGHT = 2;
    localparam int WALL_DOWN  = 1;
    localparam int WALL_LEFT  = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CHECK,
        ST_DONE
    } state_t;
endpackage

// File: rtl/maze_move_check.sv
// Combinational move legality check: wall bit plus grid-edge test, and the target tile.
// Shared by the player sequencer and any AI/replay controller.
module maze_move_check
    import maze_pkg::*;
(
    input  logic [WALL_W-1:0] walls,
    input  logic [1:0]        dir,
    input  logic [ROW_W-1:0]  row,
    input  logic [COL_W-1:0]  col,
    input  logic [ROW_W-1:0]  num_rows,
    input  logic [COL_W-1:0]  num_cols,
    output logic              blk,
    output logic [ROW_W-1:0]  next_row,
    output logic [COL_W-1:0]  next_col
);
    // Edge tests stop the 3-bit arithmetic below from wrapping into a legal-looking tile.
    always_comb begin
        blk      = 1'b0;
        next_row = row;
        next_col = col;
        case (dir)
            DIR_UP: begin
                blk      = walls[WALL_UP] | (row == '0);
                next_row = row - ROW_W'(1);
            end
            DIR_RIGHT: begin
                blk      = walls[WALL_RIGHT] | (col == num_cols - COL_W'(1));
                next_col = col + COL_W'(1);
            end
            DIR_DOWN: begin
                blk      = walls[WALL_DOWN] | (row == num_rows - ROW_W'(1));
                next_row = row + ROW_W'(1);
            end
            default: begin
                blk      = walls[WALL_LEFT] | (col == '0);
                next_col = col - COL_W'(1);
            end
        endcase
    end
endmodule

// File: rtl/maze_move_ctrl.sv
// Player-movement sequencer: accept a direction, fetch the tile's walls, commit or reject.
// Holds position, saturating move count and goal status for the renderer and game FSM.
module maze_move_ctrl
    import maze_pkg::*;
#(
    parameter logic [ROW_W-1:0] START_ROW = 3'd0,
    parameter logic [COL_W-1:0] START_COL = 3'd0,
    parameter logic [ROW_W-1:0] GOAL_ROW  = 3'd4,
    parameter logic [COL_W-1:0] GOAL_COL  = 3'd4,
    parameter int               CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              move_valid,
    input  logic [1:0]        move_dir,
    output logic              move_ready,
    output logic [ROW_W-1:0]  maze_row,
    output logic [COL_W-1:0]  maze_col,
    input  logic [WALL_W-1:0] maze_walls,
    input  logic [ROW_W-1:0]  num_rows,
    input  logic [COL_W-1:0]  num_cols,
    output logic [ROW_W-1:0]  pos_row,
    output logic [COL_W-1:0]  pos_col,
    output logic              moved,
    output logic              blocked,
    output logic              at_goal,
    output logic [CNT_W-1:0]  move_count
);
    state_t            state, state_nxt;
    logic [1:0]        dir_q;
    logic [WALL_W-1:0] walls_q;
    logic              blk;
    logic [ROW_W-1:0]  next_row;
    logic [COL_W-1:0]  next_col;
    logic              commit_goal;

    maze_move_check u_check (
        .walls    (walls_q),
        .dir      (dir_q),
        .row      (pos_row),
        .col      (pos_col),
        .num_rows (num_rows),
        .num_cols (num_cols),
        .blk      (blk),
        .next_row (next_row),
        .next_col (next_col)
    );

    assign maze_row    = pos_row;
    assign maze_col    = pos_col;
    assign at_goal     = (pos_row == GOAL_ROW) && (pos_col == GOAL_COL);
    assign commit_goal = !blk && (next_row == GOAL_ROW) && (next_col == GOAL_COL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        move_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                move_ready = !at_goal;
                if (at_goal)         state_nxt = ST_DONE;
                else if (move_valid) state_nxt = ST_FETCH;
            end
            ST_FETCH: state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = commit_goal ? ST_DONE : ST_IDLE;
            default:  state_nxt = ST_DONE;
        endcase
        if (restart) state_nxt = ST_IDLE;
    end

    // Restart drops any in-flight move without emitting a moved/blocked pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_row    <= START_ROW;
            pos_col    <= START_COL;
            move_count <= '0;
            moved      <= 1'b0;
            blocked    <= 1'b0;
            dir_q      <= '0;
            walls_q    <= '0;
        end else if (restart) begin
            pos_row    <= START_ROW;
            pos_col    <= START_COL;
            move_count <= '0;
            moved      <= 1'b0;
            blocked    <= 1'b0;
        end else begin
            moved   <= 1'b0;
            blocked <= 1'b0;
            if (state == ST_IDLE && move_valid && move_ready) dir_q <= move_dir;
            if (state == ST_FETCH) walls_q <= maze_walls;
            if (state == ST_CHECK) begin
                if (!blk) begin
                    pos_row <= next_row;
                    pos_col <= next_col;
                    if (move_count != '1) move_count <= move_count + CNT_W'(1);
                    moved <= 1'b1;
                end else begin
                    blocked <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_maze_move_ctrl.sv
// Bench for maze_move_ctrl: directed moves plus random mazes against a grid model.
// A narrow move counter keeps the saturation case reachable in a short run.
module tb_maze_move_ctrl;
    localparam int CW = 4;
    localparam int GR = 4;
    localparam int GC = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          restart = 1'b0;
    logic          move_valid = 1'b0;
    logic [1:0]    move_dir = 2'd0;
    logic          move_ready;
    logic [2:0]    maze_row, maze_col;
    logic [3:0]    maze_walls;
    logic [2:0]    num_rows = 3'd7;
    logic [2:0]    num_cols = 3'd7;
    logic [2:0]    pos_row, pos_col;
    logic          moved, blocked, at_goal;
    logic [CW-1:0] move_count;

    logic [3:0] wmap [0:7][0:7];
    int vecs = 0;
    int errs = 0;
    int m_r = 0, m_c = 0, m_cnt = 0;

    always #5 clk = ~clk;
    always_comb maze_walls = wmap[maze_row][maze_col];

    maze_move_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .restart(restart),
        .move_valid(move_valid), .move_dir(move_dir), .move_ready(move_ready),
        .maze_row(maze_row), .maze_col(maze_col), .maze_walls(maze_walls),
        .num_rows(num_rows), .num_cols(num_cols),
        .pos_row(pos_row), .pos_col(pos_col),
        .moved(moved), .blocked(blocked), .at_goal(at_goal),
        .move_count(move_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_goal();
        return (m_r == GR) && (m_c == GC);
    endfunction

    // Reference rule: a move is rejected by the wall on that side or by leaving the grid.
    function automatic bit m_blocked(input int d, output int nr, output int nc);
        int wb;
        nr = m_r; nc = m_c;
        case (d)
            0:       begin nr = m_r - 1; wb = 3; end
            1:       begin nc = m_c + 1; wb = 2; end
            2:       begin nr = m_r + 1; wb = 1; end
            default: begin nc = m_c - 1; wb = 0; end
        endcase
        return wmap[m_r][m_c][wb] || nr < 0 || nc < 0 ||
               nr >= int'(num_rows) || nc >= int'(num_cols);
    endfunction

    task automatic chk_status(input string tag, input bit exp_ready);
        chk({tag, "_pos_row"}, 32'(pos_row), 32'(m_r));
        chk({tag, "_pos_col"}, 32'(pos_col), 32'(m_c));
        chk({tag, "_count"},   32'(move_count), 32'(m_cnt));
        chk({tag, "_at_goal"}, 32'(at_goal), 32'(m_goal()));
        chk({tag, "_ready"},   32'(move_ready), 32'(exp_ready));
    endtask

    task automatic clear_map();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) wmap[r][c] = 4'h0;
    endtask

    // Called at a negedge while the DUT sits in IDLE (or DONE).
    task automatic do_move(input int d);
        bit b;
        int nr, nc;
        if (m_goal()) begin
            chk("done_ready0", 32'(move_ready), 32'd0);
            move_valid = 1'b1;
            move_dir   = 2'(d);
            repeat (3) begin
                @(negedge clk);
                chk("done_ready", 32'(move_ready), 32'd0);
                chk("done_pulse", 32'({moved, blocked}), 32'd0);
                chk_status("done", 1'b0);
            end
            move_valid = 1'b0;
            return;
        end
        chk("idle_ready", 32'(move_ready), 32'd1);
        b = m_blocked(d, nr, nc);
        move_valid = 1'b1;
        move_dir   = 2'(d);
        @(negedge clk);
        move_valid = 1'b0;
        move_dir   = 2'($urandom);
        chk("fetch_ready", 32'(move_ready), 32'd0);
        chk("fetch_pulse", 32'({moved, blocked}), 32'd0);
        @(negedge clk);
        chk("check_ready", 32'(move_ready), 32'd0);
        chk("check_pulse", 32'({moved, blocked}), 32'd0);
        if (!b) begin
            m_r = nr; m_c = nc;
            if (m_cnt < (1 << CW) - 1) m_cnt++;
        end
        @(negedge clk);
        chk("moved",   32'(moved),   32'(!b));
        chk("blocked", 32'(blocked), 32'(b));
        chk_status("post", !m_goal());
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        m_r = 0; m_c = 0; m_cnt = 0;
        chk("rst_pulse", 32'({moved, blocked}), 32'd0);
        chk_status("restart", 1'b1);
    endtask

    // Restart k cycles after the handshake: 1 = during FETCH, 2 = during CHECK.
    task automatic abort_at(input int k);
        chk("abort_ready", 32'(move_ready), 32'd1);
        move_valid = 1'b1;
        move_dir   = 2'd1;
        @(negedge clk);
        move_valid = 1'b0;
        if (k == 2) @(negedge clk);
        do_restart();
        @(negedge clk);
        chk("abort_pulse", 32'({moved, blocked}), 32'd0);
        chk_status("abort", 1'b1);
    endtask

    initial begin
        clear_map();
        #12;
        chk_status("reset", 1'b1);
        chk("reset_pulse", 32'({moved, blocked}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_status("reset_rel", 1'b1);

        // Open move, then wall block and top/left edge blocks.
        do_move(1);
        do_restart();
        wmap[0][0] = 4'b0100;
        do_move(1);
        wmap[0][0] = 4'b0000;
        do_move(0);
        do_move(3);

        // Right edge of a 7-column level from (2,6).
        do_move(2); do_move(2);
        repeat (6) do_move(1);
        do_move(1);

        // Bottom edge of a 5-row level at (4,3), then step onto the goal.
        do_restart();
        num_rows = 3'd5;
        repeat (3) do_move(1);
        repeat (4) do_move(2);
        do_move(2);
        do_move(1);
        do_move(0);
        do_restart();

        // Reach the goal from above, sit in DONE, restart out of it.
        repeat (4) do_move(1);
        repeat (4) do_move(2);
        do_move(3);
        do_restart();

        abort_at(1);
        abort_at(2);

        // Saturation of the move counter.
        num_rows = 3'd7;
        repeat (10) begin do_move(1); do_move(3); end

        // Random mazes and level sizes.
        for (int seg = 0; seg < 8; seg++) begin
            do_restart();
            num_rows = 3'(5 + $urandom_range(0, 2));
            num_cols = 3'(5 + $urandom_range(0, 2));
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    wmap[r][c] = 4'($urandom & $urandom);
            for (int i = 0; i < 40; i++) do_move(int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
